// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-port RAM arbiter controller.
// The pin decode helper keeps the RAM control encoding in one place.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_WIDTH = 14;
    localparam int RAM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        RD_ISSUE   = 2'd2,
        RD_CAPTURE = 2'd3
    } state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic cs;
        logic we;
        logic oe;
        logic drive;
    } ram_ctrl_t;

    // The bus is driven only in WRITE, where oe is low, so drive and oe never overlap.
    function automatic ram_ctrl_t ram_ctrl_decode(input state_t s);
        ram_ctrl_t c;
        c = 4'b0000;
        case (s)
            IDLE:       c = 4'b0000;
            WRITE:      c = 4'b1101;
            RD_ISSUE:   c = 4'b1010;
            RD_CAPTURE: c = 4'b1010;
            default:    c = 4'b0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ram_arbiter_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. On a tie, the port
// that did not win last time is granted. last_grant is held by the parent.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       enable,
    input  port_id_t   last_grant,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Two-requester round-robin controller for a single-port synchronous RAM
// with a shared bidirectional data bus; returns read data as registered pulses.
module ram_arbiter_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy
);

    state_t                state_r;
    state_t                next_state_s;
    port_id_t              last_grant_r;
    port_id_t              txn_port_r;
    logic [ADDR_WIDTH-1:0] txn_addr_r;
    logic [DATA_WIDTH-1:0] txn_wdata_r;
    logic [1:0]            grant_s;
    logic                  accept_s;
    port_id_t              sel_port_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    ram_ctrl_t             ctrl_next_s;
    ram_ctrl_t             ctrl_r;
    logic                  busy_r;
    logic                  p0_rvalid_r;
    logic                  p1_rvalid_r;
    logic [DATA_WIDTH-1:0] p0_rdata_r;
    logic [DATA_WIDTH-1:0] p1_rdata_r;

    rr_arbiter2 u_arb (
        .req        ({p1_valid, p0_valid}),
        .enable     (state_r == IDLE),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign p0_ready   = grant_s[0];
    assign p1_ready   = grant_s[1];
    assign accept_s   = grant_s[0] | grant_s[1];
    assign sel_port_s = grant_s[1];

    // Request field mux for the granted port
    always_comb begin
        sel_we_s    = p0_we;
        sel_addr_s  = p0_addr;
        sel_wdata_s = p0_wdata;
        if (sel_port_s == 1'b1) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Next-state logic for the RAM cycle sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = sel_we_s ? WRITE : RD_ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE:      next_state_s = IDLE;
            RD_ISSUE:   next_state_s = RD_CAPTURE;
            RD_CAPTURE: next_state_s = IDLE;
            default:    next_state_s = IDLE;
        endcase
    end

    // Pins are registered from the next state so they never glitch on request inputs.
    assign ctrl_next_s = ram_ctrl_decode(next_state_s);

    // State, pin registers and transaction capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ctrl_r       <= 4'b0000;
            busy_r       <= 1'b0;
            last_grant_r <= 1'b1;
            txn_port_r   <= 1'b0;
            txn_addr_r   <= {ADDR_WIDTH{1'b0}};
            txn_wdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_next_s;
            busy_r  <= (next_state_s != IDLE);
            if (accept_s) begin
                last_grant_r <= sel_port_s;
                txn_port_r   <= sel_port_s;
                txn_addr_r   <= sel_addr_s;
                txn_wdata_r  <= sel_wdata_s;
            end
        end
    end

    // Read response capture: the RAM drives the bus throughout RD_CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= {DATA_WIDTH{1'b0}};
            p1_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            if (state_r == RD_CAPTURE) begin
                if (txn_port_r == 1'b0) begin
                    p0_rvalid_r <= 1'b1;
                    p0_rdata_r  <= ram_data;
                end else begin
                    p1_rvalid_r <= 1'b1;
                    p1_rdata_r  <= ram_data;
                end
            end
        end
    end

    assign ram_data  = ctrl_r.drive ? txn_wdata_r : {DATA_WIDTH{1'bz}};
    assign ram_addr  = txn_addr_r;
    assign ram_cs    = ctrl_r.cs;
    assign ram_we    = ctrl_r.we;
    assign ram_oe    = ctrl_r.oe;
    assign busy      = busy_r;
    assign p0_rvalid = p0_rvalid_r;
    assign p1_rvalid = p1_rvalid_r;
    assign p0_rdata  = p0_rdata_r;
    assign p1_rdata  = p1_rdata_r;

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Scoreboard bench for ram_arbiter_ctrl with a behavioural synchronous RAM
// on the shared bus; accepted requests push expectations, a monitor pops them.
module tb_ram_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [13:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [13:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_cs, ram_we, ram_oe, busy;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [15:0] wdata;
        int          gap;
    } op_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    op_t  opq0[$];
    op_t  opq1[$];
    exp_t expq0[$];
    exp_t expq1[$];

    int ntot = 0;
    int nbad = 0;
    int cyc  = 0;
    int n_wr_acc = 0;
    int n_we_cyc = 0;

    logic [15:0] mem    [0:16383] = '{default: 16'h0000};
    logic [15:0] shadow [0:16383] = '{default: 16'h0000};
    logic [15:0] rd_q = 16'h0000;

    ram_arbiter_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM with registered read output
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        else if (ram_cs && ram_oe) rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_q : 16'hzzzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: acceptance model, response scoreboard, bus and fairness checks
    initial begin : monitor
        logic        last_acc;
        logic        prev_we;
        logic        pw_valid;
        int          pw_cyc;
        logic [13:0] pw_addr;
        logic [15:0] pw_data;
        int          w0, w1;
        logic        s0, s1;
        exp_t        e;
        last_acc = 1'b1; prev_we = 1'b0; pw_valid = 1'b0; pw_cyc = 0;
        pw_addr = 14'h0; pw_data = 16'h0; w0 = 0; w1 = 0; s0 = 1'b0; s1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq0.delete(); expq1.delete();
                last_acc = 1'b1; prev_we = 1'b0; pw_valid = 1'b0;
                w0 = 0; w1 = 0; s0 = 1'b0; s1 = 1'b0;
            end else begin
                check("oe/we overlap", {31'd0, ram_we & ram_oe}, 32'd0);
                check("one ready", {31'd0, p0_ready & p1_ready}, 32'd0);
                if (ram_cs && ram_oe) check("read bus known", {31'd0, ^ram_data === 1'bx}, 32'd0);
                if (ram_we) begin
                    n_we_cyc++;
                    check("we pulse width", {31'd0, prev_we}, 32'd0);
                    check("we with cs", {31'd0, ram_cs}, 32'd1);
                    if (pw_valid) begin
                        check("write cycle", pw_cyc, cyc);
                        check("write addr", {18'd0, ram_addr}, {18'd0, pw_addr});
                        check("write data", {16'd0, ram_data}, {16'd0, pw_data});
                        pw_valid = 1'b0;
                    end else begin
                        ntot++; nbad++;
                        $display("FAIL write strobe: got unexpected ram_we at cycle %0d expected none", cyc);
                    end
                end
                prev_we = ram_we;
                if ((p0_valid && p0_ready) || (p1_valid && p1_ready)) begin : accept
                    logic        p;
                    logic        we;
                    logic [13:0] a;
                    logic [15:0] d;
                    p  = p1_valid && p1_ready;
                    we = p ? p1_we : p0_we;
                    a  = p ? p1_addr : p0_addr;
                    d  = p ? p1_wdata : p0_wdata;
                    if (p0_valid && p1_valid) check("arb order", {31'd0, p}, {31'd0, ~last_acc});
                    last_acc = p;
                    if (we) begin
                        shadow[a] = d;
                        n_wr_acc++;
                        pw_valid = 1'b1; pw_cyc = cyc + 1; pw_addr = a; pw_data = d;
                    end else begin
                        e.data = shadow[a];
                        e.cyc  = cyc + 3;
                        if (p) expq1.push_back(e); else expq0.push_back(e);
                    end
                end
                if (p0_valid) begin
                    if (p0_ready) begin
                        ntot++;
                        if (w0 + 1 > 4) begin
                            nbad++;
                            $display("FAIL p0 starvation: got %0d cycles expected <= 4", w0 + 1);
                        end
                        w0 = 0; s0 = 1'b0;
                    end else if (s0 || !busy) begin
                        s0 = 1'b1; w0++;
                    end
                end else begin
                    w0 = 0; s0 = 1'b0;
                end
                if (p1_valid) begin
                    if (p1_ready) begin
                        ntot++;
                        if (w1 + 1 > 4) begin
                            nbad++;
                            $display("FAIL p1 starvation: got %0d cycles expected <= 4", w1 + 1);
                        end
                        w1 = 0; s1 = 1'b0;
                    end else if (s1 || !busy) begin
                        s1 = 1'b1; w1++;
                    end
                end else begin
                    w1 = 0; s1 = 1'b0;
                end
                if (p0_rvalid) begin
                    if (expq0.size() == 0) begin
                        ntot++; nbad++;
                        $display("FAIL p0 rvalid: got pulse at cycle %0d expected none", cyc);
                    end else begin
                        e = expq0.pop_front();
                        check("p0 rdata", {16'd0, p0_rdata}, {16'd0, e.data});
                        check("p0 rvalid cycle", cyc, e.cyc);
                    end
                end
                if (p1_rvalid) begin
                    if (expq1.size() == 0) begin
                        ntot++; nbad++;
                        $display("FAIL p1 rvalid: got pulse at cycle %0d expected none", cyc);
                    end else begin
                        e = expq1.pop_front();
                        check("p1 rdata", {16'd0, p1_rdata}, {16'd0, e.data});
                        check("p1 rvalid cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_op(input int p, input logic we, input logic [13:0] a,
                           input logic [15:0] d, input int gap);
        op_t op;
        op.we = we; op.addr = a; op.wdata = d; op.gap = gap;
        if (p == 0) opq0.push_back(op); else opq1.push_back(op);
    endtask

    task automatic set_port(input int p, input logic v, input op_t op);
        if (p == 0) begin
            p0_valid = v; p0_we = op.we; p0_addr = op.addr; p0_wdata = op.wdata;
        end else begin
            p1_valid = v; p1_we = op.we; p1_addr = op.addr; p1_wdata = op.wdata;
        end
    endtask

    // Presents one port's queued ops, holding each until accepted
    task automatic drive_port(input int p);
        op_t op;
        int  t;
        bit  got;
        while ((p == 0) ? (opq0.size() > 0) : (opq1.size() > 0)) begin
            op = (p == 0) ? opq0.pop_front() : opq1.pop_front();
            if (op.gap > 0) begin
                set_port(p, 1'b0, op);
                repeat (op.gap) @(posedge clk);
                #1;
            end
            set_port(p, 1'b1, op);
            got = 1'b0;
            t = 0;
            while (!got && t < 60) begin
                @(negedge clk);
                if (rst_n && ((p == 0) ? p0_ready : p1_ready)) got = 1'b1;
                else t++;
            end
            if (!got) begin
                ntot++; nbad++;
                $display("FAIL p%0d accept: got no ready in %0d cycles expected acceptance", p, t);
            end
            @(posedge clk);
            #1;
        end
        set_port(p, 1'b0, op);
    endtask

    task automatic run_both();
        fork
            drive_port(0);
            drive_port(1);
        join
        repeat (8) @(posedge clk);
        #1;
        check("p0 drained", expq0.size(), 32'd0);
        check("p1 drained", expq1.size(), 32'd0);
    endtask

    initial begin : main
        logic [13:0] atab [0:7];
        int k;
        atab[0] = 14'h0000; atab[1] = 14'h0001; atab[2] = 14'h0FFF; atab[3] = 14'h1000;
        atab[4] = 14'h1FFF; atab[5] = 14'h2001; atab[6] = 14'h3000; atab[7] = 14'h3FFF;
        rst_n = 1'b0;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = 14'h0; p0_wdata = 16'h0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = 14'h0; p1_wdata = 16'h0;
        #3;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst cs/we/oe", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        check("rst ram_addr", {18'd0, ram_addr}, 32'd0);
        check("rst rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        check("rst p0_rdata", {16'd0, p0_rdata}, 32'd0);
        check("rst p1_rdata", {16'd0, p1_rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        push_op(0, 1'b1, 14'h0005, 16'hA5A5, 0);
        push_op(0, 1'b0, 14'h0005, 16'h0000, 0);
        run_both();
        check("p0 read 0x0005", {16'd0, p0_rdata}, 32'h0000A5A5);

        push_op(1, 1'b1, 14'h0FFF, 16'h1111, 0);
        push_op(1, 1'b1, 14'h1000, 16'h2222, 0);
        push_op(1, 1'b1, 14'h3FFF, 16'h3333, 0);
        push_op(1, 1'b0, 14'h0FFF, 16'h0000, 0);
        push_op(1, 1'b0, 14'h1000, 16'h0000, 0);
        push_op(1, 1'b0, 14'h3FFF, 16'h0000, 0);
        run_both();
        check("p1 read 0x3FFF", {16'd0, p1_rdata}, 32'h00003333);

        push_op(0, 1'b1, 14'h0001, 16'hBEEF, 0);
        push_op(1, 1'b1, 14'h2001, 16'hCAFE, 0);
        run_both();

        // Reset asserted while a read sits in RD_ISSUE
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 14'h0005;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ram_oe && k < 20);
        check("mid-read oe seen", {31'd0, ram_oe}, 32'd1);
        #1 rst_n = 1'b0;
        p0_valid = 1'b0;
        #1;
        check("mid-rst cs/we/oe", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        check("mid-rst busy", {31'd0, busy}, 32'd0);
        check("mid-rst rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        check("mid-rst p0_rdata", {16'd0, p0_rdata}, 32'd0);

        // Contention straight out of reset: port 0 must win the first tie
        push_op(0, 1'b0, 14'h0001, 16'h0000, 0);
        push_op(1, 1'b0, 14'h2001, 16'h0000, 0);
        fork
            drive_port(0);
            drive_port(1);
            begin
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("contention p0 data", {16'd0, p0_rdata}, 32'h0000BEEF);
        check("contention p1 data", {16'd0, p1_rdata}, 32'h0000CAFE);
        check("contention drained", expq0.size() + expq1.size(), 32'd0);

        for (int i = 0; i < 10; i++) begin
            push_op(0, 1'b1, 14'h0200 + 14'(i), 16'h1000 + 16'(i), 0);
            push_op(1, 1'b0, 14'h0200 + 14'(i), 16'h0000, 0);
        end
        run_both();

        for (int i = 0; i < 100; i++) begin
            push_op(0, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 7)],
                    16'($urandom), $urandom_range(0, 2));
            push_op(1, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 7)],
                    16'($urandom), $urandom_range(0, 2));
        end
        run_both();

        check("write strobes", n_we_cyc, n_wr_acc);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
